// File: rtl/lane_deserializer_pkg.sv
// lane_deserializer_pkg: shared lane geometry defaults and FSM state encoding.
package lane_deserializer_pkg;
  localparam int D_W = 64;
  localparam int D_CW = 7;
  localparam int D_LANES = 25;
  localparam int D_LW = 5;
  typedef enum logic [1:0] {SHIFT, HOLD, PARITY} state_t;
endpackage

// File: rtl/lane_deserializer_if.sv
// lane_deserializer_if: serial input and parallel lane output bundle.
interface lane_deserializer_if import lane_deserializer_pkg::*; #(
  parameter int W = D_W,
  parameter int LW = D_LW
) ();
  logic sin, sin_valid, sin_ready;
  logic [W-1:0] dout;
  logic dout_valid, dout_ready;
  logic [LW-1:0] lane_idx;
  logic block_done, par_err;
  modport master (
    input sin, sin_valid, dout_ready,
    output sin_ready, dout, dout_valid, lane_idx, block_done, par_err
  );
  modport slave (
    output sin, sin_valid, dout_ready,
    input sin_ready, dout, dout_valid, lane_idx, block_done, par_err
  );
endinterface

// File: rtl/lane_deserializer_lane_bit_counter.sv
// lane_bit_counter: N-bit up-counter with sync clear and enable, wrapping to 0 after TERM.
module lane_bit_counter #(
  parameter int N = 7,
  parameter int TERM = 63
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic en,
  output logic [N-1:0] cnt,
  output logic term
);
  assign term = cnt == N'(TERM);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= term ? '0 : cnt + N'(1);
endmodule

// File: rtl/lane_deserializer.sv
// lane_deserializer: bit-serial to W-bit lane reassembly with block counting; LANE_PARITY_CHECK_EN adds per-lane even parity.
module lane_deserializer import lane_deserializer_pkg::*; #(
  parameter int W = D_W,
  parameter int CW = D_CW,
  parameter int LANES = D_LANES,
  parameter int LW = D_LW
) (
  input logic clk,
  input logic rst,
  input logic clr,
  lane_deserializer_if.master bus
);
  state_t st, nxt;
  logic [W-1:0] sr, dout, shifted, word;
  logic [CW-1:0] bcnt;
  logic [LW-1:0] lcnt, lane_idx;
  logic sin_ready, dout_valid, block_done, bterm, lterm, last;
  logic acc, free, xfer, done_w, load, shift_en;
  assign acc = bus.sin_valid & sin_ready;
  assign free = !dout_valid | bus.dout_ready;
  assign xfer = dout_valid & bus.dout_ready;
  assign shift_en = acc & (st == SHIFT);
  assign shifted = {bus.sin, sr[W-1:1]};
`ifdef LANE_PARITY_CHECK_EN
  logic px, par_err;
  assign done_w = acc & (st == PARITY);
  assign word = sr;
`else
  assign done_w = shift_en & bterm;
  assign word = (st == SHIFT) ? shifted : sr;
`endif
  assign load = (done_w & free) | ((st == HOLD) & bus.dout_ready);
  always_comb begin
    nxt = st;
    if (st == HOLD) nxt = bus.dout_ready ? SHIFT : HOLD;
    else if (done_w) nxt = free ? SHIFT : HOLD;
`ifdef LANE_PARITY_CHECK_EN
    else if (shift_en & bterm) nxt = PARITY;
`endif
  end
  lane_bit_counter #(.N(CW), .TERM(W-1)) u_bits (
    .clk(clk), .rst(rst), .clr(clr), .en(shift_en), .cnt(bcnt), .term(bterm)
  );
  lane_bit_counter #(.N(LW), .TERM(LANES-1)) u_lanes (
    .clk(clk), .rst(rst), .clr(clr), .en(load), .cnt(lcnt), .term(lterm)
  );
  // last remembers whether the word on dout closes a block, so block_done follows its transfer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= SHIFT;
      sr <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      sin_ready <= 1'b0;
      lane_idx <= '0;
      last <= 1'b0;
      block_done <= 1'b0;
    end else if (clr) begin
      st <= SHIFT;
      dout_valid <= 1'b0;
      sin_ready <= 1'b1;
      block_done <= 1'b0;
    end else begin
      st <= nxt;
      sin_ready <= nxt != HOLD;
      if (shift_en) sr <= shifted;
      if (load) begin
        dout <= word;
        lane_idx <= lcnt;
        last <= lterm;
      end
      dout_valid <= load | (dout_valid & !bus.dout_ready);
      block_done <= xfer & last;
    end
`ifdef LANE_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      px <= 1'b0;
      par_err <= 1'b0;
    end else if (clr) begin
      px <= 1'b0;
      par_err <= 1'b0;
    end else begin
      px <= done_w ? 1'b0 : shift_en ? px ^ bus.sin : px;
      if (done_w) par_err <= par_err | (px ^ bus.sin);
    end
  assign bus.par_err = par_err;
`else
  assign bus.par_err = 1'b0;
`endif
  assign bus.sin_ready = sin_ready;
  assign bus.dout = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.lane_idx = lane_idx;
  assign bus.block_done = block_done;
endmodule

// File: tb/tb_lane_deserializer.sv
// tb_lane_deserializer: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_lane_deserializer;
  import lane_deserializer_pkg::*;
  typedef struct packed {
    logic [63:0] d;
    logic [4:0] idx;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int bd_cnt = 0;
  int stalls = 0;
  bit count_stall = 0;
  logic [4:0] lane_n = '0;
  logic bd_exp = 1'b0;
  logic prev_hold = 1'b0;
  logic [63:0] prev_d = '0;
  localparam logic [63:0] LA = 64'hA5A5_5A5A_C3C3_3C3C;
  localparam logic [63:0] LB = 64'h0F0F_F0F0_1234_8765;

  always #5 clk = ~clk;

  lane_deserializer_if bus ();
  lane_deserializer dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus.master));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      bd_exp = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (bd_exp || bus.block_done) chk("block_done", 64'(bus.block_done), 64'(bd_exp));
      if (bus.block_done) bd_cnt++;
      if (prev_hold && bus.dout_valid) chk("hold_stable", bus.dout, prev_d);
      bd_exp = bus.dout_valid && bus.dout_ready && !clr && bus.lane_idx == 5'(D_LANES - 1);
      if (bus.dout_valid && bus.dout_ready && !clr) begin
        if (q.size() == 0) chk("unexpected_word", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("dout", bus.dout, e.d);
          chk("lane_idx", 64'(bus.lane_idx), 64'(e.idx));
        end
      end
      prev_hold = bus.dout_valid && !bus.dout_ready && !clr;
      prev_d = bus.dout;
    end
  end

  task automatic send_bit(input logic b);
    logic r;
    bus.sin = b;
    bus.sin_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk) r = bus.sin_ready;
      @(posedge clk);
      #1;
      if (r) return;
      if (count_stall) stalls++;
    end
    chk("sin_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_lane(input logic [63:0] v, input logic bad_par = 1'b0);
    q.push_back('{d: v, idx: lane_n});
    lane_n = (lane_n == 5'(D_LANES - 1)) ? 5'd0 : lane_n + 5'd1;
    for (int i = 0; i < 64; i++) send_bit(v[i]);
`ifdef LANE_PARITY_CHECK_EN
    send_bit(^v ^ bad_par);
`else
    if (bad_par) chk("bad_par_unused", 64'd0, 64'd0 + 64'(bad_par) - 64'd1);
`endif
  endtask

  task automatic idle(input int n);
    bus.sin_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    bus.sin_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    lane_n = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.sin = 1'b0;
    bus.sin_valid = 1'b0;
    bus.dout_ready = 1'b1;
    #1 rst = 1'b0;
    #11;
    chk("rst_dout", bus.dout, 64'd0);
    chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    chk("rst_sin_ready", 64'(bus.sin_ready), 64'd0);
    chk("rst_block_done", 64'(bus.block_done), 64'd0);
    chk("rst_par_err", 64'(bus.par_err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("sin_ready_after_rst", 64'(bus.sin_ready), 64'd1);

    send_lane(64'hDEADBEEF_01234567);
    bus.sin_valid = 1'b0;
    chk("valid_after_last_bit", 64'(bus.dout_valid), 64'd1);
    idle(2);

    pulse_clr();
    bd_cnt = 0;
    stalls = 0;
    count_stall = 1;
    for (int i = 0; i < D_LANES + 1; i++) send_lane(64'(i));
    count_stall = 0;
    idle(3);
    chk("b2b_stalls", 64'(stalls), 64'd0);
    chk("b2b_block_done_count", 64'(bd_cnt), 64'd1);

    bus.dout_ready = 1'b0;
    send_lane(LA);
    send_lane(LB);
    idle(22);
    chk("bp_sin_ready_hold", 64'(bus.sin_ready), 64'd0);
    chk("bp_dout_held", bus.dout, LA);
    chk("bp_valid_held", 64'(bus.dout_valid), 64'd1);
    bus.dout_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_sin_ready_back", 64'(bus.sin_ready), 64'd1);
    chk("bp_lane1_loaded", bus.dout, LB);
    chk("bp_valid_kept", 64'(bus.dout_valid), 64'd1);
    idle(2);

    for (int i = 0; i < 30; i++) send_bit(1'(i % 3 == 0));
    #2 rst = 1'b0;
    #1;
    chk("arst_dout", bus.dout, 64'd0);
    chk("arst_dout_valid", 64'(bus.dout_valid), 64'd0);
    chk("arst_sin_ready", 64'(bus.sin_ready), 64'd0);
    chk("arst_lane_idx", 64'(bus.lane_idx), 64'd0);
    chk("arst_block_done", 64'(bus.block_done), 64'd0);
    bus.sin_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    lane_n = '0;
    chk("arst_queue_empty", 64'(q.size()), 64'd0);
    send_lane(64'h0123_4567_89AB_CDEF);
    idle(3);

    for (int i = 0; i < 10; i++) send_bit(1'b1);
    pulse_clr();
    send_lane(64'hFEDC_BA98_7654_3210);
    idle(3);

`ifdef LANE_PARITY_CHECK_EN
    chk("par_err_clean", 64'(bus.par_err), 64'd0);
    send_lane(64'h1, 1'b1);
    idle(2);
    chk("par_err_set", 64'(bus.par_err), 64'd1);
    send_lane(64'h3);
    idle(2);
    chk("par_err_sticky", 64'(bus.par_err), 64'd1);
`else
    chk("par_err_tied", 64'(bus.par_err), 64'd0);
`endif

    idle(3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
